// File: rtl/alu_accum_sched_pkg.sv
// Shared types and widths for the alu_accum scheduler.
// Holds the FSM state encoding and the captured command payload.
package alu_accum_sched_pkg;

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 3;
  localparam int unsigned RW  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  typedef struct packed {
    logic [DW-1:0]  ain;
    logic [DW-1:0]  bin;
    logic [OPW-1:0] opcode;
  } dp_cmd_t;

endpackage

// File: rtl/alu_accum_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Produces a one-hot grant plus its binary index.
module alu_accum_sched_rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic           hi_hit;
  logic           lo_hit;
  logic [IDW-1:0] hi_idx;
  logic [IDW-1:0] lo_idx;

  // Descending scan so the lowest index in each half (at/after ptr, before ptr) wins.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IDW'(i) >= ptr) begin
          hi_hit = 1'b1;
          hi_idx = IDW'(i);
        end else begin
          lo_hit = 1'b1;
          lo_idx = IDW'(i);
        end
      end
    end
    gnt_idx = hi_hit ? hi_idx : lo_idx;
    gnt     = (hi_hit || lo_hit) ? (NREQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/alu_accum_sched.sv
// Shares one alu_accum datapath between NREQ requesters with round-robin arbitration,
// running one operation at a time and returning results on a tagged response channel.
module alu_accum_sched
  import alu_accum_sched_pkg::*;
#(
  parameter  int unsigned NREQ   = 2,
  parameter  int unsigned DP_LAT = 1,
  localparam int unsigned IDW    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*DW-1:0]  req_ain,
  input  logic [NREQ*DW-1:0]  req_bin,
  input  logic [NREQ*OPW-1:0] req_opcode,
  output logic [DW-1:0]       dp_ain,
  output logic [DW-1:0]       dp_bin,
  output logic [OPW-1:0]      dp_opcode,
  output logic                dp_start,
  input  logic [RW-1:0]       dp_dataout,
  input  logic                dp_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RW-1:0]       rsp_data,
  output logic                rsp_zero,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);

  localparam int unsigned CW = $clog2(DP_LAT + 1);

  sched_state_t   state;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cur_id;
  logic [CW-1:0]  wait_cnt;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0] gnt_idx;
  dp_cmd_t        sel_cmd;
  logic           take;

  alu_accum_sched_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is only offered while idle, so at most one op is ever in flight.
  assign req_ready = (state == IDLE) ? gnt : '0;
  assign take      = |(req_valid & req_ready);

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_cmd.ain    = req_ain[i*DW +: DW];
        sel_cmd.bin    = req_bin[i*DW +: DW];
        sel_cmd.opcode = req_opcode[i*OPW +: OPW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      wait_cnt  <= '0;
      dp_ain    <= '0;
      dp_bin    <= '0;
      dp_opcode <= '0;
      dp_start  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      dp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            dp_ain    <= sel_cmd.ain;
            dp_bin    <= sel_cmd.bin;
            dp_opcode <= sel_cmd.opcode;
            cur_id    <= gnt_idx;
            dp_start  <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= CW'(DP_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          // Counter hits zero on this edge: datapath output is valid now.
          if (wait_cnt == CW'(1)) begin
            wait_cnt  <= '0;
            rsp_data  <= dp_dataout;
            rsp_zero  <= dp_zero;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
